seq_hit_logger: RTL

//  Downstream consumer of the 10101 sequence detector's one-cycle `out` pulse.

---
 rtl/seq_hit_logger_pkg.sv | 15 +
 rtl/seq_hit_logger_if.sv | 22 ++
 rtl/seq_hit_logger_hit_ts_fifo.sv | 97 +++++++++
 rtl/seq_hit_logger.sv | 86 ++++++++
 4 files changed

// File: rtl/seq_hit_logger_pkg.sv
// Shared defaults for the hit logger: counter widths, FIFO depth, IRQ threshold.
package seq_hit_logger_pkg;

  localparam int TS_W_DEF   = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int THRESH_DEF = 8;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

  // Pointer width for a given depth; a single-entry FIFO still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/seq_hit_logger_if.sv
// Valid/ready read port carrying timestamps out of the hit logger.
interface seq_hit_logger_if #(
  parameter int TS_W = 16
);

  logic            rd_valid;
  logic            rd_ready;
  logic [TS_W-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/seq_hit_logger_hit_ts_fifo.sv
// Synchronous timestamp FIFO with registered head output; accepts push+pop while full.
module hit_ts_fifo
  import seq_hit_logger_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ONE_OCC  = OCC_W'(1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_nxt;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == FULL_OCC);
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign rd_nxt  = rd_ptr_q + PTR_W'(1);
  assign dout    = dout_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    dout_d   = dout_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_nxt;
      end

      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + ONE_OCC;
        2'b01:   occ_d = occ_q - ONE_OCC;
        default: occ_d = occ_q;
      endcase

      // Head register tracks the entry that will sit at rd_ptr after this edge;
      // a fresh push into an (about to be) empty FIFO bypasses the memory.
      if (pop_ok) begin
        if (occ_q > ONE_OCC) begin
          dout_d = mem_q[rd_nxt];
        end else if (push_ok) begin
          dout_d = din;
        end
      end else if (push_ok && empty) begin
        dout_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps detector hits into a FIFO and keeps a saturating hit count, sticky overflow and IRQ.
module seq_hit_logger
  import seq_hit_logger_pkg::*;
#(
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hit,
  input  logic             clr,
  seq_hit_logger_if.master rd,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             ovf,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  assign accept = hit & en & ~clr;
  assign pop    = ~fifo_empty & rd.rd_ready & ~clr;

  always_comb begin
    ts_d      = ts_q + TS_W'(1);
    hit_cnt_d = hit_cnt_q;
    ovf_d     = ovf_q;

    if (clr) begin
      hit_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (accept) begin
      if (hit_cnt_q != CNT_MAX) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
      // Only a hit that finds the FIFO full with no slot freed this cycle is lost.
      if (fifo_full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      hit_cnt_q <= hit_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  hit_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (accept),
    .din   (ts_q),
    .pop   (pop),
    .dout  (rd.rd_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rd.rd_valid = ~fifo_empty;
  assign hit_cnt     = hit_cnt_q;
  assign ovf         = ovf_q;
  assign irq         = (hit_cnt_q >= THRESH_V);

endmodule
